// File: rtl/lsu_dmem_port_if.sv
// Request/response and data-memory signals of the load/store unit.
// master: the LSU side; slave: the pipeline plus data memory side.
interface lsu_dmem_port_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_addr;
    logic [3:0]  wmem;
    logic [4:0]  rmem;
    logic [31:0] store_data;
    logic [31:0] load_data;

    modport master (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, load_data,
        output req_ready, resp_valid, resp_rdata, resp_err,
               mem_addr, wmem, rmem, store_data
    );

    modport slave (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, load_data,
        input  req_ready, resp_valid, resp_rdata, resp_err,
               mem_addr, wmem, rmem, store_data
    );
endinterface

// File: rtl/lsu_dmem_port.sv
// RV32I load/store unit driving a word-indexed data memory port.
// Define LSU_RMW_EN to store SB/SH by read-modify-write instead of lane writes.
module lsu_dmem_port #(
    parameter int unsigned ADDR_W = 15
) (
    input logic             clk,
    input logic             rst,
    lsu_dmem_port_if.master bus
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ACCESS = 3'd1,
        RMW_RD = 3'd2,
        RMW_WR = 3'd3,
        RESP   = 3'd4
    } state_e;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    state_e      state_q, state_d;
    logic        we_q, we_d;
    logic        sign_q, sign_d;
    logic        err_q, err_d;
    logic [1:0]  size_q, size_d;
    logic [1:0]  off_q, off_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] maddr_q, maddr_d;
    logic [31:0] rdata_q, rdata_d;
`ifdef LSU_RMW_EN
    logic [31:0] word_q, word_d;
    logic [31:0] byte_mask_c;
    logic [31:0] merged_c;
`endif

    logic        ready_c;
    logic        accept_c;
    logic        legal_c;
    logic        misaligned_c;
    logic [1:0]  req_size_c;
    logic [3:0]  lanes_c;
    logic        unused_addr_hi;

    // Request decode straight from the handshake inputs.
    always_comb begin
        req_size_c   = bus.req_funct3[1:0];
        ready_c      = (state_q == IDLE) || (state_q == RESP);
        accept_c     = bus.req_valid && ready_c;
        legal_c      = bus.req_we ? (bus.req_funct3 inside {3'b000, 3'b001, 3'b010})
                                  : (bus.req_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
        misaligned_c = ((req_size_c == SZ_H) && bus.req_addr[0]) ||
                       ((req_size_c == SZ_W) && (bus.req_addr[1:0] != 2'b00));
    end

    assign unused_addr_hi = ^bus.req_addr[31:ADDR_W+2];

    // Byte-lane code of the registered request.
    always_comb begin
        case (size_q)
            SZ_B:    lanes_c = 4'b0001 << off_q;
            SZ_H:    lanes_c = 4'b0011 << {off_q[1], 1'b0};
            default: lanes_c = 4'b1111;
        endcase
    end

`ifdef LSU_RMW_EN
    always_comb begin
        byte_mask_c = {{8{lanes_c[3]}}, {8{lanes_c[2]}}, {8{lanes_c[1]}}, {8{lanes_c[0]}}};
        merged_c    = (word_q & ~byte_mask_c) | ((wdata_q << {off_q, 3'b000}) & byte_mask_c);
    end
`endif

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        sign_d  = sign_q;
        err_d   = err_q;
        size_d  = size_q;
        off_d   = off_q;
        wdata_d = wdata_q;
        maddr_d = maddr_q;
        rdata_d = rdata_q;
`ifdef LSU_RMW_EN
        word_d  = word_q;
`endif
        case (state_q)
            IDLE, RESP: begin
                state_d = IDLE;
                if (accept_c) begin
                    we_d    = bus.req_we;
                    size_d  = req_size_c;
                    off_d   = bus.req_addr[1:0];
                    sign_d  = !bus.req_we && !bus.req_funct3[2] && (req_size_c != SZ_W);
                    maddr_d = 32'(bus.req_addr[ADDR_W+1:2]);
                    rdata_d = '0;
                    err_d   = !legal_c || misaligned_c;
                    case (req_size_c)
                        SZ_B:    wdata_d = {24'b0, bus.req_wdata[7:0]};
                        SZ_H:    wdata_d = {16'b0, bus.req_wdata[15:0]};
                        default: wdata_d = bus.req_wdata;
                    endcase
                    if (!legal_c || misaligned_c) state_d = RESP;
`ifdef LSU_RMW_EN
                    else if (bus.req_we && (req_size_c != SZ_W)) state_d = RMW_RD;
`endif
                    else state_d = ACCESS;
                end
            end
            ACCESS: begin
                if (!we_q) rdata_d = bus.load_data;
                state_d = RESP;
            end
`ifdef LSU_RMW_EN
            RMW_RD: begin
                word_d  = bus.load_data;
                state_d = RMW_WR;
            end
            RMW_WR: state_d = RESP;
`endif
            default: state_d = IDLE;
        endcase
    end

    // Memory strobes depend only on state and registered fields, so reset kills them at once.
    always_comb begin
        bus.wmem       = 4'b0000;
        bus.rmem       = 5'b00000;
        bus.store_data = '0;
        case (state_q)
            ACCESS: begin
                if (we_q) begin
                    bus.wmem       = lanes_c;
                    bus.store_data = wdata_q;
                end else begin
                    bus.rmem = {sign_q, lanes_c};
                end
            end
`ifdef LSU_RMW_EN
            RMW_RD: bus.rmem = 5'b01111;
            RMW_WR: begin
                bus.wmem       = 4'b1111;
                bus.store_data = merged_c;
            end
`endif
            default: ;
        endcase
    end

    assign bus.req_ready  = ready_c;
    assign bus.resp_valid = (state_q == RESP);
    assign bus.resp_rdata = rdata_q;
    assign bus.resp_err   = err_q;
    assign bus.mem_addr   = maddr_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            sign_q  <= 1'b0;
            err_q   <= 1'b0;
            size_q  <= 2'b00;
            off_q   <= 2'b00;
            wdata_q <= '0;
            maddr_q <= '0;
            rdata_q <= '0;
`ifdef LSU_RMW_EN
            word_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            sign_q  <= sign_d;
            err_q   <= err_d;
            size_q  <= size_d;
            off_q   <= off_d;
            wdata_q <= wdata_d;
            maddr_q <= maddr_d;
            rdata_q <= rdata_d;
`ifdef LSU_RMW_EN
            word_q  <= word_d;
`endif
        end
    end

endmodule

// File: tb/tb_lsu_dmem_port.sv
// Bench for lsu_dmem_port: transaction-level reference model plus falling-edge data memory.
module tb_lsu_dmem_port;
    localparam int unsigned ADDR_W = 15;
    localparam int unsigned MW     = 256;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    lsu_dmem_port_if bus ();
    lsu_dmem_port #(.ADDR_W(ADDR_W)) dut (.clk(clk), .rst(rst), .bus(bus));

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    bit chk_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Data memory: read extension is combinational, writes land on the falling edge.
    logic [31:0] dmem [MW];
    logic [31:0] gold [MW];
    bit          bd_we = 1'b0;
    int          bd_addr = 0;
    logic [31:0] bd_data = '0;
    bit          mem_init = 1'b0;
    logic [31:0] wv;

    function automatic logic [31:0] rd_ext(input logic [31:0] w, input logic [4:0] code);
        logic [31:0] v;
        int sh;
        case (code[3:0])
            4'b0010:          sh = 8;
            4'b0100, 4'b1100: sh = 16;
            4'b1000:          sh = 24;
            default:          sh = 0;
        endcase
        v = w >> sh;
        case (code[3:0])
            4'b0001, 4'b0010, 4'b0100, 4'b1000: v = code[4] ? {{24{v[7]}}, v[7:0]} : {24'b0, v[7:0]};
            4'b0011, 4'b1100:                   v = code[4] ? {{16{v[15]}}, v[15:0]} : {16'b0, v[15:0]};
            4'b1111:                            v = w;
            default:                            v = '0;
        endcase
        return v;
    endfunction

    always_comb bus.load_data = rd_ext(dmem[bus.mem_addr[7:0]], bus.rmem);

    always @(negedge clk) begin
        if (!mem_init) begin
            for (int i = 0; i < int'(MW); i++) dmem[i] = '0;
            mem_init = 1'b1;
        end
        if (bd_we) dmem[bd_addr] = bd_data;
        else if (bus.wmem != 4'b0000) begin
            case (bus.wmem)
                4'b1111: wv = bus.store_data;
                4'b0001: wv = {24'b0, bus.store_data[7:0]};
                4'b0010: wv = {16'b0, bus.store_data[7:0], 8'b0};
                4'b0100: wv = {8'b0, bus.store_data[7:0], 16'b0};
                4'b1000: wv = {bus.store_data[7:0], 24'b0};
                4'b0011: wv = {16'b0, bus.store_data[15:0]};
                4'b1100: wv = {bus.store_data[15:0], 16'b0};
                default: wv = 32'hDEAD_BEEF;
            endcase
            dmem[bus.mem_addr[7:0]] = wv;
        end
    end

    task automatic preload(input int w, input logic [31:0] v);
        bd_addr = w;
        bd_data = v;
        bd_we   = 1'b1;
        gold[w] = v;
        @(negedge clk);
        #1 bd_we = 1'b0;
    endtask

    // Expected timeline, keyed by posedge count seen at the following falling edge.
    typedef struct {
        int          due;
        logic [31:0] rdata;
        logic        err;
    } resp_t;
    resp_t       rq [$];
    logic [3:0]  t_wmem  [int];
    logic [4:0]  t_rmem  [int];
    logic [31:0] t_sd    [int];
    bit          t_busy  [int];
    logic [31:0] t_naddr [int];

    task automatic model_accept(input bit we, input logic [2:0] f3, input logic [31:0] a,
                                input logic [31:0] wd, input int e0);
        int          w;
        int          off;
        int          sz;
        bit          legal;
        bit          mis;
        logic [3:0]  lanes;
        logic [31:0] tmp;
        logic [31:0] val;
        logic [31:0] dmask;
        logic [31:0] pos;
        w     = int'(a[16:2]) % int'(MW);
        off   = int'(a[1:0]);
        sz    = int'(f3[1:0]);
        legal = we ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        mis   = (sz == 1 && a[0]) || (sz == 2 && off != 0);
        t_naddr[e0] = {17'b0, a[16:2]};
        if (!legal || mis) begin
            rq.push_back('{e0, 32'h0, 1'b1});
            return;
        end
        lanes = (sz == 0) ? 4'(1 << off) : (sz == 1) ? 4'(3 << off) : 4'hF;
        if (!we) begin
            tmp = gold[w] >> (8 * off);
            case (f3)
                3'd0:    val = {{24{tmp[7]}}, tmp[7:0]};
                3'd1:    val = {{16{tmp[15]}}, tmp[15:0]};
                3'd4:    val = tmp & 32'hFF;
                3'd5:    val = tmp & 32'hFFFF;
                default: val = gold[w];
            endcase
            t_rmem[e0] = {(f3 == 3'd0 || f3 == 3'd1), lanes};
            t_busy[e0] = 1'b1;
            rq.push_back('{e0 + 1, val, 1'b0});
        end else if (sz == 2) begin
            t_wmem[e0] = 4'hF;
            t_sd[e0]   = wd;
            t_busy[e0] = 1'b1;
            gold[w]    = wd;
            rq.push_back('{e0 + 1, 32'h0, 1'b0});
        end else begin
            dmask = (sz == 0) ? 32'hFF : 32'hFFFF;
            pos   = (wd & dmask) << (8 * off);
`ifdef LSU_RMW_EN
            t_rmem[e0]     = 5'b01111;
            t_wmem[e0 + 1] = 4'hF;
            gold[w]        = (gold[w] & ~(dmask << (8 * off))) | pos;
            t_sd[e0 + 1]   = gold[w];
            t_busy[e0]     = 1'b1;
            t_busy[e0 + 1] = 1'b1;
            rq.push_back('{e0 + 2, 32'h0, 1'b0});
`else
            t_wmem[e0] = lanes;
            t_sd[e0]   = wd & dmask;
            t_busy[e0] = 1'b1;
            gold[w]    = pos;
            rq.push_back('{e0 + 1, 32'h0, 1'b0});
`endif
        end
    endtask

    // Per-cycle compare of every DUT output against the timeline.
    logic [31:0] cur_maddr = '0;
    logic [3:0]  e_w;
    logic [4:0]  e_r;
    logic [31:0] e_sd;
    bit          e_busy;
    bit          e_v;
    logic [31:0] last_rdata = '0, last_sd = '0, last_maddr = '0;
    logic        last_err = 1'b0;
    logic [3:0]  last_wmem = '0;
    logic [4:0]  last_rmem = '0;
    int          wr_cnt = 0, rd_cnt = 0;
    int          rlog_c [$];
    logic [31:0] rlog_d [$];

    always @(negedge clk) begin
        if (chk_en) begin
            e_w    = t_wmem.exists(cyc) ? t_wmem[cyc] : 4'h0;
            e_r    = t_rmem.exists(cyc) ? t_rmem[cyc] : 5'h0;
            e_sd   = t_sd.exists(cyc) ? t_sd[cyc] : 32'h0;
            e_busy = t_busy.exists(cyc);
            if (t_naddr.exists(cyc)) cur_maddr = t_naddr[cyc];
            e_v = (rq.size() > 0) && (rq[0].due == cyc);
            chk("req_ready", 32'(bus.req_ready), 32'(!e_busy));
            chk("resp_valid", 32'(bus.resp_valid), 32'(e_v));
            if (e_v) begin
                chk("resp_rdata", bus.resp_rdata, rq[0].rdata);
                chk("resp_err", 32'(bus.resp_err), 32'(rq[0].err));
                void'(rq.pop_front());
            end
            chk("wmem", 32'(bus.wmem), 32'(e_w));
            chk("rmem", 32'(bus.rmem), 32'(e_r));
            chk("store_data", bus.store_data, e_sd);
            chk("mem_addr", bus.mem_addr, cur_maddr);
            if (bus.resp_valid) begin
                last_rdata = bus.resp_rdata;
                last_err   = bus.resp_err;
                rlog_c.push_back(cyc);
                rlog_d.push_back(bus.resp_rdata);
            end
            if (bus.wmem != 4'h0) begin
                wr_cnt++;
                last_wmem = bus.wmem;
                last_sd   = bus.store_data;
            end
            if (bus.rmem != 5'h0) begin
                rd_cnt++;
                last_rmem  = bus.rmem;
                last_maddr = bus.mem_addr;
            end
        end
    end

    task automatic send(input bit we, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input int gap);
        int n;
        if (gap > 0) begin
            bus.req_valid = 1'b0;
            repeat (gap) @(negedge clk);
        end
        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.req_funct3 = f3;
        bus.req_addr   = a;
        bus.req_wdata  = wd;
        n = 0;
        while (!bus.req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!bus.req_ready) chk("accept_timeout", 32'd0, 32'd1);
        else model_accept(we, f3, a, wd, cyc + 1);
        @(negedge clk);
        bus.req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((rq.size() > 0 || !bus.req_ready) && n < 30) begin
            @(negedge clk);
            n++;
        end
        if (rq.size() > 0) begin
            chk("resp_timeout", 32'(rq.size()), 32'd0);
            rq.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        int          wr0;
        int          rd0;
        bit          we;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] wd;
        int          gap;

        bus.req_valid  = 1'b0;
        bus.req_we     = 1'b0;
        bus.req_funct3 = 3'b000;
        bus.req_addr   = '0;
        bus.req_wdata  = '0;
        for (int i = 0; i < int'(MW); i++) gold[i] = '0;

        repeat (3) @(negedge clk);
        chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
        chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        chk("rst_resp_rdata", bus.resp_rdata, 32'd0);
        chk("rst_resp_err", 32'(bus.resp_err), 32'd0);
        chk("rst_mem_addr", bus.mem_addr, 32'd0);
        chk("rst_wmem", 32'(bus.wmem), 32'd0);
        chk("rst_rmem", 32'(bus.rmem), 32'd0);
        chk("rst_store_data", bus.store_data, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk_en = 1'b1;

        for (int i = 0; i < 64; i++) preload(i, $urandom);

        // Sub-word loads from a known word.
        preload(32'h10, 32'h8899AABB);
        send(1'b0, 3'b000, 32'h42, 32'h0, 0);
        wait_idle();
        chk("lb_rmem", 32'(last_rmem), 32'b10100);
        chk("lb_mem_addr", last_maddr, 32'h10);
        chk("lb_rdata", last_rdata, 32'hFFFFFF99);
        send(1'b0, 3'b100, 32'h42, 32'h0, 0);
        wait_idle();
        chk("lbu_rdata", last_rdata, 32'h00000099);
        send(1'b0, 3'b001, 32'h42, 32'h0, 0);
        wait_idle();
        chk("lh_rdata", last_rdata, 32'hFFFF8899);

        // Word store then load back.
        wr0 = wr_cnt;
        send(1'b1, 3'b010, 32'h80, 32'h12345678, 0);
        wait_idle();
        chk("sw_write_cycles", 32'(wr_cnt - wr0), 32'd1);
        chk("sw_wmem", 32'(last_wmem), 32'hF);
        send(1'b0, 3'b010, 32'h80, 32'h0, 0);
        wait_idle();
        chk("lw_rdata", last_rdata, 32'h12345678);

        // Byte store into the middle of a word.
        preload(32'h40, 32'h11223344);
        wr0 = wr_cnt;
        rd0 = rd_cnt;
        send(1'b1, 3'b000, 32'h101, 32'h000000AA, 0);
        wait_idle();
        chk("sb_write_cycles", 32'(wr_cnt - wr0), 32'd1);
`ifdef LSU_RMW_EN
        chk("sb_read_cycles", 32'(rd_cnt - rd0), 32'd1);
        chk("sb_wmem", 32'(last_wmem), 32'hF);
        chk("sb_store_data", last_sd, 32'h1122AA44);
        send(1'b0, 3'b010, 32'h100, 32'h0, 0);
        wait_idle();
        chk("sb_word", last_rdata, 32'h1122AA44);
`else
        chk("sb_read_cycles", 32'(rd_cnt - rd0), 32'd0);
        chk("sb_wmem", 32'(last_wmem), 32'b0010);
        send(1'b0, 3'b010, 32'h100, 32'h0, 0);
        wait_idle();
        chk("sb_word", last_rdata, 32'h0000AA00);
`endif

        // Error requests never touch memory.
        wr0 = wr_cnt;
        rd0 = rd_cnt;
        send(1'b0, 3'b010, 32'h42, 32'h0, 0);
        wait_idle();
        chk("err_lw_mis", 32'(last_err), 32'd1);
        chk("err_lw_rdata", last_rdata, 32'd0);
        send(1'b1, 3'b001, 32'h43, 32'hFFFF, 0);
        wait_idle();
        chk("err_sh_mis", 32'(last_err), 32'd1);
        send(1'b0, 3'b011, 32'h40, 32'h0, 0);
        wait_idle();
        chk("err_illegal", 32'(last_err), 32'd1);
        chk("err_no_mem_cycles", 32'(wr_cnt - wr0 + rd_cnt - rd0), 32'd0);

        // Back-to-back word loads with valid held high.
        preload(32'h20, 32'h01020304);
        preload(32'h21, 32'h05060708);
        preload(32'h22, 32'h090A0B0C);
        rlog_c.delete();
        rlog_d.delete();
        send(1'b0, 3'b010, 32'h80, 32'h0, 0);
        send(1'b0, 3'b010, 32'h84, 32'h0, 0);
        send(1'b0, 3'b010, 32'h88, 32'h0, 0);
        wait_idle();
        chk("b2b_count", 32'(rlog_c.size()), 32'd3);
        if (rlog_c.size() == 3) begin
            chk("b2b_spacing0", 32'(rlog_c[1] - rlog_c[0]), 32'd2);
            chk("b2b_spacing1", 32'(rlog_c[2] - rlog_c[1]), 32'd2);
            chk("b2b_data0", rlog_d[0], 32'h01020304);
            chk("b2b_data1", rlog_d[1], 32'h05060708);
            chk("b2b_data2", rlog_d[2], 32'h090A0B0C);
        end

        // Randomized traffic over words 0..63 with junk in the ignored upper bits.
        for (int i = 0; i < 400; i++) begin
            we = 1'($urandom_range(0, 1));
            f3 = 3'($urandom_range(0, 7));
            a  = ($urandom & 32'hFFFE_0000) | 32'($urandom_range(0, 255));
            if ($urandom_range(0, 1) == 1) begin
                if (f3[1:0] == 2'd2) a[1:0] = 2'b00;
                else if (f3[1:0] == 2'd1) a[0] = 1'b0;
            end
            wd  = $urandom;
            gap = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
            send(we, f3, a, wd, gap);
        end
        wait_idle();
        for (int i = 0; i < 64; i++) chk("mem_contents", dmem[i], gold[i]);

        // Reset in the middle of a sub-word store.
        chk_en = 1'b0;
        preload(32'h60, 32'h11223344);
        bus.req_valid  = 1'b1;
        bus.req_we     = 1'b1;
        bus.req_funct3 = 3'b000;
        bus.req_addr   = 32'h181;
        bus.req_wdata  = 32'h000000AA;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
`ifdef LSU_RMW_EN
        chk("pre_rst_rmem", 32'(bus.rmem), 32'b01111);
`else
        chk("pre_rst_wmem", 32'(bus.wmem), 32'b0010);
`endif
        rst = 1'b1;
        #1;
        chk("rst_kill_wmem", 32'(bus.wmem), 32'd0);
        chk("rst_kill_rmem", 32'(bus.rmem), 32'd0);
        repeat (2) begin
            @(negedge clk);
            chk("rst_no_resp", 32'(bus.resp_valid), 32'd0);
        end
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", 32'(bus.req_ready), 32'd1);
        chk("post_rst_no_resp", 32'(bus.resp_valid), 32'd0);
        chk("rst_word_intact", dmem[32'h60], 32'h11223344);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/lsu_dmem_port.md
# lsu_dmem_port

Load/store unit that drives the CPU's word-indexed data memory port as the initiator: it takes one memory request per handshake from the execute stage, decodes RV32I load/store width and sign from `funct3`, generates the data memory's `wmem` byte-lane and `rmem` lane/sign codes, and returns the already-extended load result. It sits between the execute/memory pipeline stage and the data memory. It sequences word reads, optional read-modify-write for sub-word stores, and misalignment errors through a small state machine.

## Interface
- `ADDR_W`, 15, word-address width of the data memory (depth 2**ADDR_W words)
- `clk`  in  1  clock; data memory samples on the falling edge, this block on the rising edge
- `rst`  in  1  asynchronous, active-high reset
- `req_valid`  in  1  request present
- `req_ready`  out  1  block can accept a request
- `req_we`  in  1  1 = store, 0 = load
- `req_funct3`  in  3  RV32I funct3 of the load/store
- `req_addr`  in  32  byte address
- `req_wdata`  in  32  store data, low-aligned (SB uses [7:0], SH uses [15:0])
- `resp_valid`  out  1  one-cycle pulse: request complete
- `resp_rdata`  out  32  load result, zero- or sign-extended; 0 for stores and errors
- `resp_err`  out  1  valid with `resp_valid`: misaligned or illegal funct3
- `mem_addr`  out  32  word index = {zeros, addr[ADDR_W+1:2]}
- `wmem`  out  4  byte-lane write code to data memory
- `rmem`  out  5  read code: [4] = sign-extend, [3:0] = lanes
- `store_data`  out  32  write data to data memory
- `load_data`  in  32  extended read data from data memory, valid before the next rising edge

## Operation
- States: IDLE, ACCESS, RMW_RD, RMW_WR, RESP.
- `req_ready` = 1 in IDLE and RESP. A request is accepted on a rising edge with `req_valid && req_ready`. The request is registered, so inputs may change after acceptance.
- Decode:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
  - Any other code is illegal and sets err.
- Misalignment sets err: halfword with addr[0]=1; word with addr[1:0]≠0.
- Lanes: byte = 4'b0001 << addr[1:0]; half = 4'b0011 << {addr[1],0}; word = 4'b1111.
- `rmem` = {signed, lanes}, with signed = 1 for LB/LH only; LW always uses 5'b01111.
- Error request: goes to RESP directly with `resp_err=1` and `resp_rdata=0`. No memory cycle occurs; `wmem` and `rmem` stay 0.
- Load: in ACCESS, drive `mem_addr` and `rmem`. Capture `load_data` into `resp_rdata` at the end of ACCESS, then go to RESP.
- SW: in ACCESS, drive `wmem=4'b1111` and `store_data=req_wdata`, then go to RESP.
- SB/SH: behaviour depends on LSU_RMW_EN (see Configuration).
- RESP: `resp_valid=1` for exactly one cycle. On the same edge, go to ACCESS (or RMW_RD) if a new request is accepted, else IDLE.
- Outside the memory-active states, `wmem=0`, `rmem=0` and `store_data=0`. `mem_addr` holds the last request's value.
- `wmem` and `rmem` are decoded from state and registered request fields. `rst` therefore clears them immediately, and no write reaches the falling edge after reset assertion.
- Address bits above ADDR_W+1 are ignored and are not an error.

## Timing
- Reset values:
  - State: IDLE.
  - `req_ready=1`, `resp_valid=0`, `resp_rdata=0`, `resp_err=0`.
  - `mem_addr=0`, `wmem=0`, `rmem=0`, `store_data=0`.
- Latency is counted from the accept edge E0 to `resp_valid` high:
  - Load, SW, sub-word store without RMW: 1 cycle (ACCESS between E0 and E1; `resp_valid` high from E1 to E2).
  - Sub-word store with RMW: 2 cycles.
  - Error: 0 memory cycles; `resp_valid` high from E0 to E1.
- Sustained throughput: one load or word store every 2 cycles, because RESP overlaps the next accept.
- The memory read occurs on the falling edge inside ACCESS or RMW_RD. `load_data` is combinational from `rmem`, so `rmem` is held stable for the whole cycle.
- A `rst` pulse in any state aborts the request and no `resp_valid` is issued. In RMW_WR, the write has not happened if `rst` rises before that cycle's falling edge.

## Configuration
- `LSU_RMW_EN` defined: SB/SH use read-modify-write.
  - RMW_RD: `rmem=5'b01111`; the word is captured at the end of the cycle.
  - RMW_WR: the selected byte or half is merged into its lane position and written with `wmem=4'b1111`; `store_data` is the merged word.
  - Other bytes are preserved.
- `LSU_RMW_EN` not defined: SB/SH issue in ACCESS with the lane `wmem` code and low-aligned `store_data`. The data memory positions the data itself, and the other bytes of the word are written as zero. Documented limitation.

## Test plan
- Word pre-loaded with 0x8899AABB at byte addr 0x40:
  - LB at 0x42 → `rmem=5'b10100`, `mem_addr=0x10`, `resp_rdata=0xFFFFFF99`.
  - LBU at 0x42 → `resp_rdata=0x00000099`.
  - LH at 0x42 → `resp_rdata=0xFFFF8899`.
- SW 0x12345678 to 0x80, then LW 0x80 → `wmem=4'b1111` for exactly one cycle; load returns 0x12345678; each request shows `resp_valid` one cycle after accept.
- With `LSU_RMW_EN`, word = 0x11223344, SB 0xAA to addr+1 → one RMW_RD cycle, then one write of 0x1122AA44; without the macro → `wmem=4'b0010`, and the word reads 0x0000AA00.
- Error requests each give `resp_err=1`, `resp_rdata=0`, `resp_valid` the cycle after accept, and `wmem`/`rmem` never nonzero:
  - LW at 0x42.
  - SH at 0x43.
  - funct3=011 (illegal).
- Back-to-back LW requests with `req_valid` held high → accepts on alternate edges; `resp_valid` alternates 1,0,1; results arrive in order.
- Assert `rst` mid-RMW_RD → `wmem`/`rmem` go to 0 immediately; the memory word is unchanged; no `resp_valid`; `req_ready=1` after release.
